vga_text_arbiter: RTL and testbench
===================================

VGA_TEXT_ARBITER -- requirements
Module: vga_text_arbiter

Interface
REQ-001 Parameters SHALL be: COLS, default 20, text columns; ROWS, default 15, text rows; CELL_SHIFT, default 5, log2 of the cell size in pixels (32x32 cells).
REQ-002 clk  in  1  system/pixel clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 hpos, vpos  in  10 each  current pixel position from the timing generator (800x525 frame, 640x480 visible).
REQ-005 cpu_valid  in  1  CPU access request; cpu_we  in  1  1=write, 0=read; cpu_addr  in  9  cell index row*COLS+col; cpu_wdata  in  8  write data.
REQ-006 cpu_ready  out  1  request accepted this cycle; cpu_rvalid  out  1  read data valid; cpu_rdata  out  8  read data.
REQ-007 ram_addr  out  9, ram_we  out  1, ram_wdata  out  8: single-port text RAM port; ram_rdata  in  8, valid one cycle after the address is presented.
REQ-008 cell_char  out  8  character code for the cell currently being drawn; cell_valid  out  1  cell_char belongs to a visible cell.

Function
REQ-009 The display slot SHALL be every cycle where hpos[CELL_SHIFT-1:0]==24 and a target cell exists.
REQ-010 Target at hpos<792: col=(hpos+8)>>CELL_SHIFT, row=vpos>>CELL_SHIFT; the target SHALL exist only if col<COLS and vpos<480.
REQ-011 Target at hpos==792: col=0, row=((vpos==524)?0:vpos+1)>>CELL_SHIFT; the target SHALL exist only if that next line is <480.
REQ-012 In a display slot the block SHALL drive ram_addr=row*COLS+col and ram_we=0, and SHALL hold cpu_ready=0.
REQ-013 Outside a display slot, cpu_valid=1 SHALL give cpu_ready=1 in the same cycle (combinational), with ram_addr=cpu_addr.
REQ-014 For an accepted CPU write, ram_we=1 and ram_wdata=cpu_wdata; if cpu_addr>=COLS*ROWS, ram_we SHALL stay 0 and the write is dropped.
REQ-015 For an accepted CPU read, cpu_rvalid=1 SHALL follow exactly one cycle later with cpu_rdata=ram_rdata; out-of-range reads SHALL return 0x00.
REQ-016 A registered owner FSM SHALL track the read in flight: NONE, DISP, CPU.
REQ-017 Owner transitions: display slot -> DISP; accepted CPU read -> CPU; all other cycles -> NONE.
REQ-018 Owner DISP SHALL load ram_rdata into an internal next_cell register.
REQ-019 At hpos[CELL_SHIFT-1:0]==31 (cell boundary, includes hpos==799), cell_char<=next_cell.
REQ-020 At the same boundary, cell_valid<=1 only if the upcoming cell is visible under REQ-010/011, else 0.
REQ-021 Worst-case CPU stall SHALL be 1 cycle; a request held through a slot SHALL be accepted the following cycle with unchanged data.
REQ-022 cpu_rdata SHALL hold its last value when cpu_rvalid=0.

Reset
REQ-023 Reset SHALL give cell_char=0, cell_valid=0, next_cell=0, owner=NONE, cpu_rvalid=0 and cpu_rdata=0.
REQ-024 ram_we SHALL be 0 while reset=1, and cpu_ready SHALL be 0 while reset=1.
REQ-025 A read in flight when reset asserts SHALL be discarded, with no cpu_rvalid pulse after reset.

Structure
REQ-026 Package vga_console_pkg SHALL hold the timing constants (800/525/640/480), the prefetch offset 24, COLS, ROWS, CELL_SHIFT and the owner enum.
REQ-027 Target row/col/address computation SHALL be the combinational sub-module vga_cell_addr.

Verification
REQ-028 RAM[0]=0x41, hpos=792, vpos=524 -> ram_addr=0 at hpos=792; at hpos=799 cell_char<=0x41 and cell_valid<=1.
REQ-029 cpu_valid write addr=5 data=0x7E asserted at hpos=24 -> cpu_ready=0 at hpos=24; cpu_ready=1, ram_we=1, ram_addr=5 at hpos=25.
REQ-030 CPU read addr=299 with RAM[299]=0x33 -> cpu_rvalid=1, cpu_rdata=0x33 one cycle after accept.
REQ-031 CPU write addr=300 -> cpu_ready=1, ram_we=0; a later read of addr=300 -> cpu_rdata=0x00.
REQ-032 hpos=632, vpos=100 -> no display slot (col 20 out of range); at hpos=639 cell_valid<=0.
REQ-033 reset asserted the cycle after a CPU read accept -> cpu_rvalid stays 0, cell_char=0 after reset.

Source files
------------

// File: rtl/vga_console_pkg.sv
// Shared constants and owner encoding for the VGA text console.
package vga_console_pkg;

    // 800x525 frame, 640x480 visible
    localparam int unsigned HTotal   = 800;
    localparam int unsigned VTotal   = 525;
    localparam int unsigned HVisible = 640;
    localparam int unsigned VVisible = 480;

    // Pixel phase inside a cell at which the next cell's character is fetched
    localparam int unsigned PrefetchOff = 24;

    // Default text geometry: 20x15 cells of 32x32 pixels
    localparam int unsigned TextCols  = 20;
    localparam int unsigned TextRows  = 15;
    localparam int unsigned CellShift = 5;

    // Owner of the RAM read currently in flight
    typedef logic [1:0] owner_t;
    localparam owner_t OwnNone = 2'd0;
    localparam owner_t OwnDisp = 2'd1;
    localparam owner_t OwnCpu  = 2'd2;

endpackage

// File: rtl/vga_cell_addr.sv
// Maps a pixel position to the text cell that must be fetched next.
module vga_cell_addr
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS       = TextCols,
    parameter int unsigned CELL_SHIFT = CellShift
) (
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic [8:0] addr,
    output logic       exists
);

    // Pixels between the fetch point and the next cell boundary
    localparam logic [9:0] Lead     = 10'((1 << CELL_SHIFT) - PrefetchOff);
    // Last fetch of a line targets column 0 of the following line
    localparam logic [9:0] LastSlot = 10'(HTotal) - Lead;
    localparam logic [9:0] VLast    = 10'(VTotal - 1);
    localparam logic [9:0] VVis     = 10'(VVisible);
    localparam logic [9:0] ColsW    = 10'(COLS);
    localparam logic [8:0] ColsA    = 9'(COLS);

    logic [9:0] next_line;
    logic [9:0] col;
    logic [8:0] row;

    // Target cell selection and visibility
    always_comb begin
        next_line = (vpos == VLast) ? 10'd0 : vpos + 10'd1;
        col       = 10'd0;
        row       = 9'd0;
        exists    = 1'b0;
        if (hpos == LastSlot) begin
            row    = 9'(next_line >> CELL_SHIFT);
            exists = (next_line < VVis);
        end else if (hpos < LastSlot) begin
            col    = (hpos + Lead) >> CELL_SHIFT;
            row    = 9'(vpos >> CELL_SHIFT);
            exists = (col < ColsW) && (vpos < VVis);
        end
        addr = row * ColsA + col[8:0];
    end

endmodule

// File: rtl/vga_text_arbiter.sv
// Shares a single-port text RAM between display prefetch and CPU access.
module vga_text_arbiter
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS       = TextCols,
    parameter int unsigned ROWS       = TextRows,
    parameter int unsigned CELL_SHIFT = CellShift
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       cpu_valid,
    input  logic       cpu_we,
    input  logic [8:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic [8:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [7:0] cell_char,
    output logic       cell_valid
);

    localparam logic [CELL_SHIFT-1:0] SlotPhase = CELL_SHIFT'(PrefetchOff);
    localparam logic [8:0]            Cells     = 9'(COLS * ROWS);

    logic       phase_slot;
    logic       boundary;
    logic [9:0] tgt_hpos;
    logic [8:0] disp_addr;
    logic       tgt_exists;
    logic       slot;
    logic       in_range;
    owner_t     owner_q, owner_d;
    logic       rd_oob_q;
    logic [7:0] next_cell_q;
    logic [7:0] rdata_q;

    assign phase_slot = (hpos[CELL_SHIFT-1:0] == SlotPhase);
    assign boundary   = (hpos[CELL_SHIFT-1:0] == '1);
    // Slot and boundary never coincide, so one address unit serves both: at a
    // boundary it is asked about the slot of the cell just finishing, whose
    // target is exactly the upcoming cell.
    assign tgt_hpos   = boundary ? {hpos[9:CELL_SHIFT], SlotPhase} : hpos;

    vga_cell_addr #(
        .COLS       (COLS),
        .CELL_SHIFT (CELL_SHIFT)
    ) u_cell_addr (
        .hpos   (tgt_hpos),
        .vpos   (vpos),
        .addr   (disp_addr),
        .exists (tgt_exists)
    );

    // Port arbitration: display slot wins, CPU takes every other cycle
    always_comb begin
        slot      = phase_slot && tgt_exists;
        in_range  = (cpu_addr < Cells);
        cpu_ready = cpu_valid && !slot && !reset;
        ram_addr  = slot ? disp_addr : cpu_addr;
        ram_we    = cpu_ready && cpu_we && in_range;
        ram_wdata = cpu_wdata;
        if (slot) begin
            owner_d = OwnDisp;
        end else if (cpu_ready && !cpu_we) begin
            owner_d = OwnCpu;
        end else begin
            owner_d = OwnNone;
        end
    end

    // Read return path; a read caught by reset is suppressed
    always_comb begin
        cpu_rvalid = (owner_q == OwnCpu) && !reset;
        if (cpu_rvalid) begin
            cpu_rdata = rd_oob_q ? 8'h00 : ram_rdata;
        end else begin
            cpu_rdata = rdata_q;
        end
    end

    // Owner tracking, prefetch capture and cell output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OwnNone;
            rd_oob_q    <= 1'b0;
            next_cell_q <= 8'h00;
            rdata_q     <= 8'h00;
            cell_char   <= 8'h00;
            cell_valid  <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            rd_oob_q <= !in_range;
            if (owner_q == OwnDisp) begin
                next_cell_q <= ram_rdata;
            end
            if (cpu_rvalid) begin
                rdata_q <= cpu_rdata;
            end
            if (boundary) begin
                cell_char  <= next_cell_q;
                cell_valid <= tgt_exists;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Scoreboard bench for vga_text_arbiter with a behavioural text RAM.
module tb_vga_text_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       cpu_valid, cpu_we;
    logic [8:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] cell_char;
    logic       cell_valid;

    logic [7:0] mem [512];

    int         errors;
    int         checks;
    logic [7:0] exp_rd[$];
    logic [8:0] exp_cell[$];   // {valid, char}
    bit         done;
    bit         mon_bnd;
    logic [8:0] cell_e;
    logic [7:0] rd_e;

    always #5 clk = ~clk;

    vga_text_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .cpu_valid  (cpu_valid),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .cell_char  (cell_char),
        .cell_valid (cell_valid)
    );

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic val,
                        input logic we, input logic [8:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        hpos      = h;
        vpos      = v;
        cpu_valid = val;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        done   = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0]   = 8'h41;
        mem[7]   = 8'h11;
        mem[61]  = 8'h5A;
        mem[299] = 8'h33;
        mem[300] = 8'h55;
        hpos      = 10'd700;
        vpos      = 10'd500;
        reset     = 1'b1;
        cpu_valid = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 9'd3;
        cpu_wdata = 8'hAA;

        fork
            // Monitor: pops expectations when the DUT presents read data or a cell
            begin
                while (!done) begin
                    @(posedge clk);
                    mon_bnd = (hpos[4:0] == 5'd31) && !reset;
                    @(negedge clk);
                    if (mon_bnd) begin
                        if (exp_cell.size() == 0) begin
                            check("cell_event_expected", 32'(exp_cell.size()), 1);
                        end else begin
                            cell_e = exp_cell.pop_front();
                            check("cell_char", 32'(cell_char), 32'(cell_e[7:0]));
                            check("cell_valid", 32'(cell_valid), 32'(cell_e[8]));
                        end
                    end
                    if (cpu_rvalid === 1'b1) begin
                        if (exp_rd.size() == 0) begin
                            check("rvalid_expected", 32'(exp_rd.size()), 1);
                        end else begin
                            rd_e = exp_rd.pop_front();
                            check("cpu_rdata", 32'(cpu_rdata), 32'(rd_e));
                        end
                    end
                end
            end
            // Stimulus
            begin
                #2;
                check("rst_cpu_ready", 32'(cpu_ready), 0);
                check("rst_ram_we", 32'(ram_we), 0);
                repeat (2) @(posedge clk);
                #1;
                check("rst_cell_char", 32'(cell_char), 0);
                check("rst_cell_valid", 32'(cell_valid), 0);
                check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
                check("rst_cpu_rdata", 32'(cpu_rdata), 0);
                reset     = 1'b0;
                cpu_valid = 1'b0;
                step(700, 500, 0, 0, 0, 0);

                // End-of-frame fetch of cell 0 for line 0
                for (int h = 792; h <= 799; h++) begin
                    step(10'(h), 524, 0, 0, 0, 0);
                    if (h == 792) begin
                        check("eof_ram_addr", 32'(ram_addr), 0);
                        check("eof_ram_we", 32'(ram_we), 0);
                    end
                    if (h == 799) exp_cell.push_back({1'b1, 8'h41});
                end

                // CPU write stalled by a display slot, accepted next cycle
                step(24, 100, 1, 1, 5, 8'h7E);
                check("slot_cpu_ready", 32'(cpu_ready), 0);
                check("slot_ram_addr", 32'(ram_addr), 61);
                check("slot_ram_we", 32'(ram_we), 0);
                step(25, 100, 1, 1, 5, 8'h7E);
                check("wr_cpu_ready", 32'(cpu_ready), 1);
                check("wr_ram_we", 32'(ram_we), 1);
                check("wr_ram_addr", 32'(ram_addr), 5);
                check("wr_ram_wdata", 32'(ram_wdata), 8'h7E);
                for (int h = 26; h <= 31; h++) begin
                    step(10'(h), 100, 0, 0, 0, 0);
                    if (h == 31) exp_cell.push_back({1'b1, 8'h5A});
                end

                // CPU read of the last cell, then hold of rdata
                step(700, 500, 1, 0, 299, 0);
                check("rd299_ready", 32'(cpu_ready), 1);
                check("rd299_ram_we", 32'(ram_we), 0);
                check("rd299_ram_addr", 32'(ram_addr), 299);
                exp_rd.push_back(8'h33);
                step(700, 500, 0, 0, 0, 0);
                step(700, 500, 0, 0, 0, 0);
                check("hold_rvalid", 32'(cpu_rvalid), 0);
                check("hold_rdata", 32'(cpu_rdata), 8'h33);

                // Read back the stalled write
                step(700, 500, 1, 0, 5, 0);
                exp_rd.push_back(8'h7E);
                step(700, 500, 0, 0, 0, 0);

                // Out-of-range write dropped, out-of-range read returns zero
                step(700, 500, 1, 1, 300, 8'h99);
                check("oob_wr_ready", 32'(cpu_ready), 1);
                check("oob_wr_ram_we", 32'(ram_we), 0);
                step(700, 500, 1, 0, 300, 0);
                check("oob_rd_ready", 32'(cpu_ready), 1);
                exp_rd.push_back(8'h00);
                step(700, 500, 0, 0, 0, 0);

                // Column 20 has no slot; the boundary at 639 clears cell_valid
                step(632, 100, 1, 0, 7, 0);
                check("col20_ready", 32'(cpu_ready), 1);
                check("col20_ram_addr", 32'(ram_addr), 7);
                exp_rd.push_back(8'h11);
                for (int h = 633; h <= 639; h++) begin
                    step(10'(h), 100, 0, 0, 0, 0);
                    if (h == 639) exp_cell.push_back({1'b0, 8'h5A});
                end

                // Reset lands while a read is in flight
                step(700, 500, 1, 0, 299, 0);
                check("pre_rst_ready", 32'(cpu_ready), 1);
                @(posedge clk);
                #1;
                reset     = 1'b1;
                cpu_valid = 1'b0;
                #1;
                check("inflight_rvalid", 32'(cpu_rvalid), 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                check("post_rst_cell_char", 32'(cell_char), 0);
                check("post_rst_cell_valid", 32'(cell_valid), 0);
                check("post_rst_rdata", 32'(cpu_rdata), 0);
                step(700, 500, 0, 0, 0, 0);
                step(700, 500, 0, 0, 0, 0);
                check("post_rst_rvalid", 32'(cpu_rvalid), 0);
                done = 1'b1;
            end
        join

        check("rd_queue_drained", 32'(exp_rd.size()), 0);
        check("cell_queue_drained", 32'(exp_cell.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
